led_bcd_display: RTL
====================

// Module: led_bcd_display
// PURPOSE
//  Downstream display stage for the calculator's 8-bit result bus (ledOut).
//  Converts the byte to 3 decimal digits with a sequential double-dabble
//  (shift-add-3) engine, then time-multiplexes 4 active-low 7-segment digits.
//  Digit 3 is the sign digit. Sits between calculator output and board pins.
// PARAMETERS
//  REFRESH_BITS  17  refresh counter width; each digit is lit 2^(REFRESH_BITS-2) clk (min 3)
// PORTS
//  clk    in   1  system clock
//  rst    in   1  synchronous reset, active-high
//  value  in   8  byte to display (calculator result)
//  seg    out  7  segments {g,f,e,d,c,b,a}, active-low, registered
//  an     out  4  digit anodes, active-low, registered; an[0]=ones
//  dp     out  1  decimal point, active-low; constant 1 (off)
//  busy   out  1  high while a conversion is in flight (CONV state)
// BEHAVIOUR
//  Reset (synchronous, active-high), also applied mid-operation:
//   state=IDLE, lastVal=0, ones/tens/hund=0, neg=0, refresh cnt=0, busy=0,
//   seg=7'h7F, an=4'hF, dp=1. Any in-flight conversion is discarded.
//  FSM IDLE/CONV/LOAD:
//   IDLE: if value!=lastVal -> lastVal<=value, shift reg<={12'b0,mag}, bit cnt<=0, ->CONV.
//   CONV: 8 cycles; each cycle add 3 to every BCD nibble >=5, then shift whole
//         20-bit reg left 1. After the 8th shift ->LOAD. busy=1 only in CONV.
//   LOAD: hund/tens/ones<=BCD nibbles, neg<=sign flag, ->IDLE.
//  Latency: value change to new digit regs = 10 clk (1 IDLE + 8 CONV + 1 LOAD).
//   Displayed pattern follows on next refresh slot of each digit.
//  Changes of value during CONV/LOAD are not sampled; back in IDLE the
//   lastVal compare retriggers, so the final stable value is always shown.
//  Value stable and equal to lastVal: no conversion, busy stays 0.
//  Refresh: cnt increments every clk, wraps at 2^REFRESH_BITS; sel=cnt[MSB:MSB-1]:
//   0->ones an=1110, 1->tens an=1101, 2->hund an=1011, 3->sign an=0111.
//   seg/an registered: 1 clk from sel change to pins.
//  Digit codes (active-low gfedcba): 0=1000000 1=1111001 2=0100100 3=0110000
//   4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000
//   blank=1111111 minus=0111111.
//  No leading-zero blanking: 7 shows as 007.
// CONFIGURATION
//  SIGNED_DISPLAY_EN defined: value is two's complement; if value[7]
//   mag=(~value+1) as 8-bit unsigned (8'h80 -> 128), neg=1, sign digit=minus;
//   else mag=value, neg=0, sign digit blank.
//  SIGNED_DISPLAY_EN undefined: mag=value (0..255), neg forced 0,
//   sign digit always blank.
// TESTING (bench uses REFRESH_BITS=4)
//  1 rst 2 clk, value=0 -> busy never rises; ones/tens/hund = 0,0,0; sign digit blank.
//  2 value 0->255 -> busy high exactly 8 clk; digits 2,5,5 at clk 10.
//  3 value=123, change to 45 on 3rd CONV clk -> 1,2,3 loaded, then reconvert; final 0,4,5.
//  4 SIGNED_DISPLAY_EN: 8'hFF -> minus,0,0,1; 8'h80 -> minus,1,2,8; undefined: 8'hFF -> blank,2,5,5.
//  5 rst during CONV with value=200 -> next clk busy=0, digits 0,0,0; release -> 2,0,0 after 10 clk.
//  6 free-run -> an 1110,1101,1011,0111 repeating, each held 4 clk, seg matches digit.

Source files
------------

// File: rtl/led_bcd_display.sv
// led_bcd_display
//   Display stage for the calculator's 8-bit result bus. A sequential
//   double-dabble (shift-add-3) engine converts the byte to three BCD digits.
//   Four active-low 7-segment digits are then time-multiplexed; digit 3 shows
//   the sign.
//
//   Optional feature macro: SIGNED_DISPLAY_EN
//     defined   : value is two's complement; negative values show a minus sign
//                 and their magnitude (8'h80 -> -128).
//     undefined : value is unsigned 0..255; the sign digit is always blank.
//
// Ports
//   clk    in   1  system clock
//   rst    in   1  synchronous reset, active-high
//   value  in   8  byte to display
//   seg    out  7  segments {g,f,e,d,c,b,a}, active-low, registered
//   an     out  4  digit anodes, active-low, registered; an[0] = ones
//   dp     out  1  decimal point, active-low, always off
//   busy   out  1  high while a conversion is in flight
//
// Parameters
//   REFRESH_BITS  refresh counter width (min 3); each digit is lit for
//                 2^(REFRESH_BITS-2) clk cycles.

module led_bcd_display #(
   parameter int unsigned REFRESH_BITS = 17
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] value,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       dp,
   output logic       busy
);

   typedef enum logic [1:0] {StIdle, StConv, StLoad} state_t;

   state_t                  state;
   logic [7:0]              last_val;
   logic [19:0]             shift;     // {hund, tens, ones, binary}
   logic [2:0]              bit_cnt;
   logic                    conv_neg;  // sign captured with the value being converted
   logic [3:0]              ones;
   logic [3:0]              tens;
   logic [3:0]              hund;
   logic                    neg;
   logic [REFRESH_BITS-1:0] refresh_cnt;

   logic [7:0]  mag;
   logic        sign_in;
   logic [19:0] adjusted;
   logic [1:0]  sel;
   logic [6:0]  seg_next;
   logic [3:0]  an_next;

`ifdef SIGNED_DISPLAY_EN
   assign sign_in = value[7];
   assign mag     = value[7] ? (~value + 8'd1) : value;
`else
   assign sign_in = 1'b0;
   assign mag     = value;
`endif

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] c;
      case (d)
         4'd0:    c = 7'b1000000;
         4'd1:    c = 7'b1111001;
         4'd2:    c = 7'b0100100;
         4'd3:    c = 7'b0110000;
         4'd4:    c = 7'b0011001;
         4'd5:    c = 7'b0010010;
         4'd6:    c = 7'b0000010;
         4'd7:    c = 7'b1111000;
         4'd8:    c = 7'b0000000;
         4'd9:    c = 7'b0010000;
         default: c = 7'b1111111;
      endcase
      return c;
   endfunction

   // Add-3 correction on the BCD nibbles; the shift happens on registration.
   assign adjusted = {add3(shift[19:16]), add3(shift[15:12]), add3(shift[11:8]), shift[7:0]};

   // Conversion FSM. Value changes during CONV/LOAD are ignored; the
   // last_val compare in IDLE picks them up afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= StIdle;
         last_val <= 8'd0;
         shift    <= 20'd0;
         bit_cnt  <= 3'd0;
         conv_neg <= 1'b0;
         ones     <= 4'd0;
         tens     <= 4'd0;
         hund     <= 4'd0;
         neg      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (value != last_val) begin
                  last_val <= value;
                  shift    <= {12'd0, mag};
                  conv_neg <= sign_in;
                  bit_cnt  <= 3'd0;
                  busy     <= 1'b1;
                  state    <= StConv;
               end
            end
            StConv: begin
               shift   <= {adjusted[18:0], 1'b0};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  busy  <= 1'b0;
                  state <= StLoad;
               end
            end
            StLoad: begin
               hund  <= shift[19:16];
               tens  <= shift[15:12];
               ones  <= shift[11:8];
               neg   <= conv_neg;
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign sel = refresh_cnt[REFRESH_BITS-1 -: 2];

   always_comb begin
      an_next  = 4'b1111;
      seg_next = 7'h7F;
      unique case (sel)
         2'd0: begin an_next = 4'b1110; seg_next = seg_code(ones); end
         2'd1: begin an_next = 4'b1101; seg_next = seg_code(tens); end
         2'd2: begin an_next = 4'b1011; seg_next = seg_code(hund); end
         2'd3: begin an_next = 4'b0111; seg_next = neg ? 7'b0111111 : 7'b1111111; end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_cnt <= '0;
         seg         <= 7'h7F;
         an          <= 4'hF;
      end else begin
         refresh_cnt <= refresh_cnt + 1'b1;
         seg         <= seg_next;
         an          <= an_next;
      end
   end

   assign dp = 1'b1;

endmodule
